bit_serial_adder: RTL and testbench

Sequential bit-serial adder that sits directly downstream of the team's combinational half-/full-adder cells. It accepts two WIDTH-bit operands plus a carry-in on a start pulse and adds them LSB-first, one bit per clock, through a single full-adder cell with a registered carry. It presents the registered sum and carry-out with a one-cycle done pulse. The block trades latency for area wherever a wide adder is not justified.

---
 rtl/bit_serial_adder_pkg.sv | 16 +
 rtl/full_adder_cell.sv | 13 +
 rtl/bit_serial_adder.sv | 99 +++++++++
 tb/tb_bit_serial_adder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// counter-width helper.
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // One extra bit so the counter can hold WIDTH-1 for any WIDTH >= 1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full adder used as the serial datapath cell.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell, a registered carry and
// held sum/carry outputs that only change on completion or reset.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, psum_q, sum_q;
  logic [WIDTH-1:0]  psum_next;
  logic [CntW-1:0]   cnt_q;
  logic              c_q, cout_q;
  logic              fa_s, fa_cout;
  logic              accept, last;

  full_adder_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign accept    = start_in && ((state_q == StIdle) || (state_q == StDone));
  assign last      = (state_q == StShift) && (cnt_q == LastCnt);
  // New sum bit enters at the MSB so the LSB-first result ends up aligned.
  assign psum_next = (psum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_in) state_d = StShift;
      StShift: if (cnt_q == LastCnt) state_d = StDone;
      StDone:  state_d = start_in ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_out = 1'b0;
    done_out = 1'b0;
    busy_out = (state_q == StShift);
    done_out = (state_q == StDone);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_q    <= '0;
      b_q    <= '0;
      psum_q <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_q   <= a_in;
      b_q   <= b_in;
      c_q   <= carry_in;
      cnt_q <= '0;
    end else if (state_q == StShift) begin
      a_q    <= a_q >> 1;
      b_q    <= b_q >> 1;
      psum_q <= psum_next;
      c_q    <= fa_cout;
      cnt_q  <= cnt_q + CntW'(1);
      if (last) begin
        sum_q  <= psum_next;
        cout_q <= fa_cout;
      end
    end
  end

  assign sum_out   = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder at WIDTH=8 and WIDTH=1.
module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, c8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, c1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) u_dut8 (
    .clk_in    (clk),
    .rst_in    (rst),
    .start_in  (start8),
    .a_in      (a8),
    .b_in      (b8),
    .carry_in  (c8),
    .busy_out  (busy8),
    .done_out  (done8),
    .sum_out   (sum8),
    .carry_out (cout8)
  );

  bit_serial_adder #(.WIDTH(1)) u_dut1 (
    .clk_in    (clk),
    .rst_in    (rst),
    .start_in  (start1),
    .a_in      (a1),
    .b_in      (b1),
    .carry_in  (c1),
    .busy_out  (busy1),
    .done_out  (done1),
    .sum_out   (sum1),
    .carry_out (cout1)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer addition; done expected exactly 8 cycles after start.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input string name);
    logic [8:0] exp;
    int n;
    exp = {1'b0, a} + {1'b0, b} + {8'b0, c};
    a8 = a; b8 = b; c8 = c; start8 = 1'b1;
    step();
    start8 = 1'b0;
    chk({name, "_busy"}, 32'(busy8), 32'(1));
    n = 0;
    while (!done8 && n < 20) begin
      step();
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(8));
    chk({name, "_sum"}, 32'(sum8), 32'(exp[7:0]));
    chk({name, "_cout"}, 32'(cout8), 32'(exp[8]));
  endtask

  task automatic run1(input logic a, input logic b, input logic c, input string name);
    logic [1:0] exp;
    int n;
    exp = 2'(a) + 2'(b) + 2'(c);
    a1 = a; b1 = b; c1 = c; start1 = 1'b1;
    step();
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 10) begin
      step();
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(1));
    chk({name, "_sum"}, 32'(sum1), 32'(exp[0]));
    chk({name, "_cout"}, 32'(cout1), 32'(exp[1]));
    step();
  endtask

  initial begin
    int n;
    int seen;
    logic [7:0] ra, rb;
    logic       rc;

    vecs[0] = '{a: 8'h0F, b: 8'h01, c: 1'b0, exp_sum: 8'h10, exp_cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, c: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, exp_sum: 8'hFF, exp_cout: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, c: 1'b1, exp_sum: 8'h01, exp_cout: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, c: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};

    rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_busy", 32'(busy8), 32'(0));
    chk("rst_done", 32'(done8), 32'(0));
    chk("rst_sum", 32'(sum8), 32'(0));
    chk("rst_cout", 32'(cout8), 32'(0));
    chk("rst_busy1", 32'(busy1), 32'(0));

    // Directed table, also checking that the result is held after the pulse.
    for (int i = 0; i < 5; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].c, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl_sum", i), 32'(sum8), 32'(vecs[i].exp_sum));
      chk($sformatf("vec%0d_tbl_cout", i), 32'(cout8), 32'(vecs[i].exp_cout));
      step();
      chk($sformatf("vec%0d_pulse", i), 32'(done8), 32'(0));
      chk($sformatf("vec%0d_hold", i), 32'(sum8), 32'(vecs[i].exp_sum));
    end

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      run8(ra, rb, rc, $sformatf("rnd%0d", i));
    end

    // Back-to-back: second request held through SHIFT, accepted in DONE.
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; start8 = 1'b1;
    step();
    a8 = 8'hAA; b8 = 8'h55;
    n = 0;
    while (!done8 && n < 20) begin
      step();
      n++;
    end
    chk("b2b_first_latency", 32'(n), 32'(8));
    chk("b2b_first_sum", 32'(sum8), 32'(8'h46));
    chk("b2b_first_cout", 32'(cout8), 32'(0));
    step();
    n++;
    start8 = 1'b0;
    chk("b2b_second_accept_cycle", 32'(n), 32'(9));
    chk("b2b_second_busy", 32'(busy8), 32'(1));
    n = 0;
    while (!done8 && n < 20) begin
      step();
      n++;
    end
    chk("b2b_second_latency", 32'(n), 32'(8));
    chk("b2b_second_sum", 32'(sum8), 32'(8'hFF));
    chk("b2b_second_cout", 32'(cout8), 32'(0));
    step();

    // Reset four cycles into an add while a prior result is held.
    run8(8'h12, 8'h34, 1'b0, "pre_rst");
    step();
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (3) step();
    chk("midop_busy", 32'(busy8), 32'(1));
    chk("midop_sum_held", 32'(sum8), 32'(8'h46));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy8), 32'(0));
    chk("midrst_done", 32'(done8), 32'(0));
    chk("midrst_sum", 32'(sum8), 32'(0));
    chk("midrst_cout", 32'(cout8), 32'(0));
    seen = 0;
    repeat (12) begin
      step();
      if (done8) seen = 1;
    end
    chk("midrst_no_done", 32'(seen), 32'(0));

    // Reset wins over a coincident start.
    rst = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
    step();
    rst = 1'b0; start8 = 1'b0;
    chk("rst_start_busy", 32'(busy8), 32'(0));
    step();
    chk("rst_start_busy2", 32'(busy8), 32'(0));
    chk("rst_start_done", 32'(done8), 32'(0));

    for (int i = 0; i < 8; i++) begin
      run1(1'(i >> 2), 1'(i >> 1), 1'(i), $sformatf("w1_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
